servo_drive_ctrl: RTL and testbench

Parametrised differential-drive servo controller for the line follower. Sits between the PID block and the two continuous-rotation servo PWM generators. Converts each PID sample into one of three actions:
- a forward command;
- a timed left or right pivot, with duration proportional to error magnitude;
- a latched stop on the reserved stop code.

Optional per-channel slew limiting smooths output transitions.

---
 rtl/servo_drive_pkg.sv | 21 ++
 rtl/servo_ramp.sv | 40 ++++
 rtl/servo_drive_ctrl.sv | 161 ++++++++++++++++
 tb/tb_servo_drive_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_drive_pkg.sv
// Shared types, default constants and helpers for the servo drive controller.
// The optional output slew limiting is enabled by defining SERVO_RAMP_EN.
package servo_drive_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TURN_L = 2'd1,
    ST_TURN_R = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  localparam int CENTER_DEF    = 500;
  localparam int STOP_CODE_DEF = 239;
  localparam int L_ON_DEF      = 157;
  localparam int R_ON_DEF      = 137;

  function automatic logic [31:0] abs_err(input logic signed [31:0] e);
    return e[31] ? -e : e;
  endfunction

endpackage

// File: rtl/servo_ramp.sv
// Per-channel slew limiter: value_o walks toward target_i by at most STEP per
// cycle and lands exactly on it. Used only when SERVO_RAMP_EN is defined.
module servo_ramp #(
  parameter int W    = 8,
  parameter int STEP = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic [W-1:0] target_i,
  output logic [W-1:0] value_o
);

  localparam logic [W:0] STEP_W = (W+1)'(STEP);

  logic [W-1:0] value_q, value_d;
  logic [W:0]   up_gap, down_gap;

  assign up_gap   = {1'b0, target_i} - {1'b0, value_q};
  assign down_gap = {1'b0, value_q} - {1'b0, target_i};

  always_comb begin
    value_d = value_q;
    if (clear_i) begin
      value_d = '0;
    end else if (value_q < target_i) begin
      value_d = (up_gap > STEP_W) ? value_q + STEP_W[W-1:0] : target_i;
    end else if (value_q > target_i) begin
      value_d = (down_gap > STEP_W) ? value_q - STEP_W[W-1:0] : target_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/servo_drive_ctrl.sv
// Differential-drive servo controller: PID sample -> forward / timed pivot / stop.
// Define SERVO_RAMP_EN to slew-limit both servo outputs through servo_ramp.
module servo_drive_ctrl
  import servo_drive_pkg::*;
#(
  parameter int PID_W     = 11,
  parameter int SERVO_W   = 8,
  parameter int CNT_W     = 21,
  parameter int CENTER    = CENTER_DEF,
  parameter int DEADBAND  = 4,
  parameter int STOP_CODE = STOP_CODE_DEF,
  parameter int DUR_SHIFT = 0,
  parameter int L_ON      = L_ON_DEF,
  parameter int R_ON      = R_ON_DEF,
  parameter int RAMP_STEP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               pid_valid,
  input  logic [PID_W-1:0]   pid_output,
  output logic [SERVO_W-1:0] servo_l,
  output logic [SERVO_W-1:0] servo_r,
  output logic               busy,
  output logic [1:0]         state_o
);

  localparam logic signed [PID_W:0] DB_S     = (PID_W+1)'(DEADBAND);
  localparam logic signed [PID_W:0] CENTER_S = (PID_W+1)'(CENTER);
  localparam logic [63:0]           DUR_MAX  = (64'd1 << CNT_W) - 64'd1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   dur_q, dur_d;
  logic               busy_q;
  logic signed [PID_W:0] err;
  logic [63:0]        dur_wide;
  logic [CNT_W-1:0]   dur_calc;
  logic               is_stop;
  logic [SERVO_W-1:0] tgt_l, tgt_r;

  assign err     = $signed({1'b0, pid_output}) - CENTER_S;
  assign is_stop = (pid_output == PID_W'(STOP_CODE));

  // Turn length saturates at the counter range and is never zero.
  always_comb begin
    dur_wide = {32'd0, abs_err(32'(err))} << DUR_SHIFT;
    if (dur_wide > DUR_MAX)    dur_calc = '1;
    else if (dur_wide == '0)   dur_calc = CNT_W'(1);
    else                       dur_calc = dur_wide[CNT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dur_d   = dur_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pid_valid) begin
            if (is_stop) begin
              state_d = ST_STOP;
            end else if (err > DB_S) begin
              state_d = ST_TURN_L;
              cnt_d   = '0;
              dur_d   = dur_calc;
            end else if (err < -DB_S) begin
              state_d = ST_TURN_R;
              cnt_d   = '0;
              dur_d   = dur_calc;
            end
          end
        end
        ST_TURN_L, ST_TURN_R: begin
          if (pid_valid && is_stop) begin
            state_d = ST_STOP;
          end else if (cnt_q == dur_q - CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (pid_valid && !is_stop) state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Targets follow the next state so outputs change on the same edge as state.
  always_comb begin
    tgt_l = '0;
    tgt_r = '0;
    if (enable) begin
      case (state_d)
        ST_IDLE:   begin tgt_l = SERVO_W'(L_ON); tgt_r = SERVO_W'(R_ON); end
        ST_TURN_L: begin tgt_r = SERVO_W'(R_ON); end
        ST_TURN_R: begin tgt_l = SERVO_W'(L_ON); end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dur_q   <= CNT_W'(1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dur_q   <= dur_d;
      busy_q  <= (state_d == ST_TURN_L) || (state_d == ST_TURN_R);
    end
  end

`ifdef SERVO_RAMP_EN
  servo_ramp #(.W(SERVO_W), .STEP(RAMP_STEP)) u_ramp_l (
    .clk      (clk),
    .rst_n    (rst),
    .clear_i  (!enable),
    .target_i (tgt_l),
    .value_o  (servo_l)
  );

  servo_ramp #(.W(SERVO_W), .STEP(RAMP_STEP)) u_ramp_r (
    .clk      (clk),
    .rst_n    (rst),
    .clear_i  (!enable),
    .target_i (tgt_r),
    .value_o  (servo_r)
  );
`else
  logic [SERVO_W-1:0] servo_l_q, servo_r_q;
  logic [31:0]        unused_ramp_step;

  assign unused_ramp_step = 32'(RAMP_STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      servo_l_q <= '0;
      servo_r_q <= '0;
    end else begin
      servo_l_q <= tgt_l;
      servo_r_q <= tgt_r;
    end
  end

  assign servo_l = servo_l_q;
  assign servo_r = servo_r_q;
`endif

  assign busy    = busy_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_servo_drive_ctrl.sv
// Self-checking bench for servo_drive_ctrl: directed scenarios plus random
// PID traffic against a mode/remaining-cycles reference model.
module tb_servo_drive_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        pid_valid = 1'b0;
  logic [10:0] pid_output = '0;
  logic [7:0]  servo_l, servo_r;
  logic        busy;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  servo_drive_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pid_valid  (pid_valid),
    .pid_output (pid_output),
    .servo_l    (servo_l),
    .servo_r    (servo_r),
    .busy       (busy),
    .state_o    (state_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: 0 forward, 1 pivot left, 2 pivot right, 3 stopped.
  int m_mode = 0;
  int m_rem  = 0;
  int exp_l = 0, exp_r = 0, exp_busy = 0, exp_state = 0;
  bit quiet = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur_of(input int mag);
    longint d = longint'(mag);
    if (d > (64'd1 << 21) - 1) d = (64'd1 << 21) - 1;
    if (d < 1) d = 1;
    return int'(d);
  endfunction

  function automatic int approach(input int cur, input int tgt);
`ifdef SERVO_RAMP_EN
    if (cur < tgt) return (tgt - cur > 4) ? cur + 4 : tgt;
    if (cur > tgt) return (cur - tgt > 4) ? cur - 4 : tgt;
    return cur;
`else
    return tgt + 0 * cur;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_rem = 0;
    exp_l = 0; exp_r = 0; exp_busy = 0; exp_state = 0;
  endtask

  task automatic model_edge();
    int e, tl, tr;
    bit stop_s;
    stop_s = (pid_output == 11'd239);
    e = int'(pid_output) - 500;
    if (!enable) begin
      m_mode = 0; m_rem = 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (pid_valid && stop_s) m_mode = 3;
      else begin
        m_rem--;
        if (m_rem == 0) m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (pid_valid && !stop_s) m_mode = 0;
    end else if (pid_valid) begin
      if (stop_s)      m_mode = 3;
      else if (e > 4)  begin m_mode = 1; m_rem = dur_of(e);  end
      else if (e < -4) begin m_mode = 2; m_rem = dur_of(-e); end
    end
    tl = (m_mode == 0 || m_mode == 2) ? 157 : 0;
    tr = (m_mode == 0 || m_mode == 1) ? 137 : 0;
    if (!enable) begin tl = 0; tr = 0; exp_l = 0; exp_r = 0; end
    exp_l = approach(exp_l, tl);
    exp_r = approach(exp_r, tr);
    exp_busy  = (m_mode == 1 || m_mode == 2) ? 1 : 0;
    exp_state = m_mode;
  endtask

  task automatic check_all();
    check_val("servo_l", 32'(servo_l), exp_l);
    check_val("servo_r", 32'(servo_r), exp_r);
    check_val("busy",    32'(busy),    exp_busy);
    check_val("state_o", 32'(state_o), exp_state);
  endtask

  task automatic cycle(input bit en, input bit v, input int pid);
    enable = en;
    pid_valid = v;
    pid_output = pid[10:0];
    if (v && !quiet) $display("txn en=%0d pid=%0d", en, pid);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Counts busy cycles starting from the current one, bounded by maxc.
  task automatic count_busy(input int maxc, output int n);
    int k = 0;
    n = busy ? 1 : 0;
    while (busy && k < maxc) begin
      cycle(1, 0, 0);
      if (busy) n++;
      k++;
    end
  endtask

  int n;

  initial begin
    #2;
    check_val("reset_l", 32'(servo_l), 0);
    check_val("reset_state", 32'(state_o), 0);
    model_reset();
    @(negedge clk) rst = 1'b1;
`ifdef SERVO_RAMP_EN
    n = 0;
    while (servo_l != 8'd157 && n < 100) begin cycle(1, 0, 0); n++; end
    check_val("ramp_l_cycles", n, 40);
`endif
    repeat (45) cycle(1, 0, 0);

    // Left pivot of 10 cycles, then reset mid-turn
    cycle(1, 1, 510);
    count_busy(30, n);
    check_val("turn_l_len", n, 10);
    cycle(1, 1, 510);
    repeat (3) cycle(1, 0, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk) rst = 1'b1;
    repeat (45) cycle(1, 0, 0);

    // Deadband, then right pivot of 20
    cycle(1, 1, 497);
    check_val("deadband_busy", 32'(busy), 0);
    cycle(1, 0, 0);
    cycle(1, 1, 480);
    count_busy(40, n);
    check_val("turn_r_len", n, 20);
    repeat (2) cycle(1, 0, 0);

    // Stop during a long right pivot, release, then a new left pivot
    cycle(1, 1, 400);
    repeat (30) cycle(1, 0, 0);
    cycle(1, 1, 239);
    check_val("stop_state", 32'(state_o), 3);
    repeat (3) cycle(1, 0, 0);
    cycle(1, 1, 520);
    check_val("release_state", 32'(state_o), 0);
    cycle(1, 1, 520);
    check_val("after_release_state", 32'(state_o), 1);
    count_busy(40, n);
    check_val("turn_l20_len", n, 20);

    // Sample dropped while busy; enable low mid-turn
    cycle(1, 1, 510);
    cycle(1, 0, 0);
    cycle(1, 1, 530);
    count_busy(30, n);
    check_val("drop_turn_len", n, 8);
    cycle(1, 1, 510);
    repeat (3) cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 1, 239);
    check_val("disabled_state", 32'(state_o), 0);
    repeat (45) cycle(1, 0, 0);

    // Randomised traffic
    quiet = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      int r, pid;
      bit en, v;
      r   = int'($urandom_range(0, 9));
      pid = (r == 0) ? 239 : (r == 1) ? int'($urandom_range(0, 2047))
                                      : 470 + int'($urandom_range(0, 60));
      en  = ($urandom_range(0, 49) != 0);
      v   = ($urandom_range(0, 7) == 0);
      cycle(en, v, pid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
